// File: rtl/prog_loader.sv
// prog_loader: writes a framed (length, data, checksum) byte stream into program memory
// from address 0 and holds the uP in reset until a load completes with a good checksum.
`default_nettype none

module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] len;
  logic [7:0]  sum;
  logic        xfer;
  logic        last_data;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                (state == S_DATA)   || (state == S_CHECK);
    xfer      = in_valid && in_ready;
    last_data = (byte_count + ADDR_W'(1)) == ADDR_W'(len);
    busy      = in_ready;
    cpu_hold  = in_ready || (state == S_ERROR);
    done      = (state == S_DONE);
    error     = (state == S_ERROR);

    // A start pulse overrides any byte offered in the same cycle.
    if (start) begin
      state_nxt = S_LEN_HI;
    end else if (xfer) begin
      case (state)
        S_LEN_HI: state_nxt = (in_data[7:4] != 4'h0) ? S_ERROR : S_LEN_LO;
        S_LEN_LO: state_nxt = ({len[11:8], in_data} == 12'd0) ? S_CHECK : S_DATA;
        S_DATA:   state_nxt = last_data ? S_CHECK : S_DATA;
        S_CHECK:  state_nxt = (in_data == sum) ? S_DONE : S_ERROR;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      len        <= 12'd0;
      sum        <= 8'd0;
      byte_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        len        <= 12'd0;
        sum        <= 8'd0;
        byte_count <= '0;
      end else if (xfer) begin
        case (state)
          S_LEN_HI: len[11:8] <= in_data[3:0];
          S_LEN_LO: len[7:0]  <= in_data;
          S_DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= byte_count;
            mem_wdata  <= DATA_W'(in_data);
            byte_count <= byte_count + ADDR_W'(1);
            sum        <= sum + in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
`default_nettype none

module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] byte_count;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  logic [11:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];

  prog_loader #(.ADDR_W(12), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  // Write log sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
  end

  // Inputs change 2 time units after a rising edge; outputs are read then.
  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) next_cycle();
    total++;
    if ({busy, cpu_hold, in_ready, mem_we, done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b hold=%b rdy=%b we=%b done=%b err=%b, want all 0",
               busy, cpu_hold, in_ready, mem_we, done, error);
    end
    total++;
    if ({mem_addr, mem_wdata, byte_count} !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: got addr=%h wdata=%h count=%h, want 0", mem_addr, mem_wdata, byte_count);
    end
    reset = 1'b1;
    next_cycle();
    pulse_start();
    total++;
    if ({busy, cpu_hold, in_ready} !== 3'b111) begin
      bad++;
      $display("FAIL start_flags: got busy=%b hold=%b rdy=%b, want 111", busy, cpu_hold, in_ready);
    end
  endtask

  task automatic test_good_load();
    logic [7:0] d [0:2];
    d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3;
    pulse_start();
    push(8'h00);
    push(8'h03);
    for (int i = 0; i < 3; i++) begin
      push(d[i]);
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== d[i]) begin
        bad++;
        $display("FAIL good_write%0d: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, i, d[i]);
      end
    end
    push(8'h16);
    total++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || byte_count !== 12'd3) begin
      bad++;
      $display("FAIL good_end: got done=%b hold=%b busy=%b err=%b count=%0d, want 1 0 0 0 3",
               done, cpu_hold, busy, error, byte_count);
    end
    total++;
    if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL good_idle: got we=%b rdy=%b, want 0 0", mem_we, in_ready);
    end
  endtask

  task automatic test_bad_checksum();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL restart_clears_done: got done=%b, want 0", done);
    end
    push(8'h00); push(8'h03); push(8'hA1); push(8'hB2); push(8'hC3);
    push(8'h17);
    total++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL badsum_end: got err=%b hold=%b done=%b busy=%b, want 1 1 0 0",
               error, cpu_hold, done, busy);
    end
    total++;
    if (wr_cnt - w0 !== 3) begin
      bad++;
      $display("FAIL badsum_writes: got %0d writes, want 3", wr_cnt - w0);
    end
  endtask

  task automatic test_header_and_empty();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    push(8'h10);
    repeat (2) next_cycle();
    total++;
    if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || wr_cnt !== w0) begin
      bad++;
      $display("FAIL bad_header: got err=%b rdy=%b hold=%b writes=%0d, want 1 0 1 0",
               error, in_ready, cpu_hold, wr_cnt - w0);
    end
    pulse_start();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL restart_clears_error: got err=%b, want 0", error);
    end
    push(8'h00); push(8'h00); push(8'h00);
    total++;
    if (done !== 1'b1 || byte_count !== 12'd0 || cpu_hold !== 1'b0 || wr_cnt !== w0) begin
      bad++;
      $display("FAIL empty_load: got done=%b count=%0d hold=%b writes=%0d, want 1 0 0 0",
               done, byte_count, cpu_hold, wr_cnt - w0);
    end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] d [0:3];
    int w0, idx;
    logic took;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    pulse_start();
    push(8'h00);
    push(8'h04);
    w0  = wr_cnt;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      in_valid = (cyc % 2 == 0);
      in_data  = d[idx];
      @(negedge clock);
      took = in_valid && in_ready;
      next_cycle();
      if (took) idx++;
    end
    in_valid = 1'b0;
    next_cycle();
    total++;
    if (idx !== 4 || wr_cnt - w0 !== 4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL toggle_count: got accepted=%0d writes=%0d busy=%b, want 4 4 1",
               idx, wr_cnt - w0, busy);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_addr[w0 + i] !== 12'(i) || wr_data[w0 + i] !== d[i]) begin
        bad++;
        $display("FAIL toggle_write%0d: got addr=%h data=%h, want addr=%h data=%h",
                 i, wr_addr[w0 + i], wr_data[w0 + i], i, d[i]);
      end
    end
    push(8'hAA);
    total++;
    if (done !== 1'b1 || byte_count !== 12'd4) begin
      bad++;
      $display("FAIL toggle_sum: got done=%b count=%0d, want 1 4", done, byte_count);
    end
  endtask

  task automatic test_restart_and_reset();
    pulse_start();
    push(8'h00); push(8'h05); push(8'h01); push(8'h02);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    next_cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (mem_we !== 1'b0 || byte_count !== 12'd0 || busy !== 1'b1 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL restart: got we=%b count=%0d busy=%b rdy=%b hold=%b, want 0 0 1 1 1",
               mem_we, byte_count, busy, in_ready, cpu_hold);
    end
    push(8'h00); push(8'h05); push(8'h07);
    total++;
    if (byte_count !== 12'd1 || mem_addr !== 12'd0 || mem_wdata !== 8'h07) begin
      bad++;
      $display("FAIL restart_write: got count=%0d addr=%h data=%h, want 1 000 07",
               byte_count, mem_addr, mem_wdata);
    end
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h08;
    next_cycle();
    reset    = 1'b1;
    in_valid = 1'b0;
    total++;
    if (mem_we !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || byte_count !== 12'd0) begin
      bad++;
      $display("FAIL mid_reset: got we=%b hold=%b busy=%b rdy=%b count=%0d, want 0 0 0 0 0",
               mem_we, cpu_hold, busy, in_ready, byte_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_header_and_empty();
    test_valid_toggle();
    test_restart_and_reset();
    repeat (2) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
